// File: rtl/sc_game_sequencer.sv
// sc_game_sequencer: Frogger game controller.
// Generates the game tick, strobes the obstacle lanes round-robin, arbitrates
// player moves against lane shifts and keeps lives, level and game-over.
// Optional build macro FROGGER_GAMESEQ_SPEEDUP_EN: when defined, each lane's
// effective period is shortened by the current level (floored at zero).
module sc_game_sequencer #(
  parameter int LANES    = 4,
  parameter int TICK_DIV = 2500000,
  parameter int LIVES    = 3
) (
  input  logic               SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic               SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic               SC_GAMESEQ_start_InLow,
  input  logic               SC_GAMESEQ_moveReq_InLow,
  input  logic [4*LANES-1:0] SC_GAMESEQ_lanePeriod_In,
  input  logic               SC_GAMESEQ_collision_InHigh,
  input  logic               SC_GAMESEQ_goal_InHigh,
  output logic [LANES-1:0]   SC_GAMESEQ_laneShift_OutLow,
  output logic               SC_GAMESEQ_lanesClear_OutLow,
  output logic               SC_GAMESEQ_playerClear_OutLow,
  output logic               SC_GAMESEQ_moveGrant_OutLow,
  output logic [2:0]         SC_GAMESEQ_lives_Out,
  output logic [2:0]         SC_GAMESEQ_level_Out,
  output logic               SC_GAMESEQ_gameOver_OutHigh
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LANES - 1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [2:0]       LEVEL_MAX  = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    TICK_WAIT,
    GRANT,
    SHIFT,
    CHECK,
    HIT,
    WIN,
    GAMEOVER
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic [PRE_W-1:0]      prescaleCount;
  logic [IDX_W-1:0]      shiftIdx;
  logic [LANES-1:0][3:0] laneCount;
  logic [LANES-1:0][3:0] effPeriod;
  logic [LANES-1:0]      dueMask;
  logic                  pendTick;
  logic                  pendMove;
  logic                  running;
  logic                  tick;
  logic                  startShift;
  logic                  moveCapture;

  // The prescaler only advances while a game is actually being played.
  assign running = (state == TICK_WAIT) || (state == GRANT) || (state == SHIFT) ||
                   (state == CHECK) || (state == HIT) || (state == WIN);
  assign tick = running && (prescaleCount == PRE_LAST);
  assign startShift = (state == TICK_WAIT) && (nextState == SHIFT);
  assign moveCapture = (state == SHIFT) || (state == CHECK) || (state == HIT) || (state == WIN);

  // Effective lane period; with the speed-up build higher levels move lanes faster.
  always_comb begin
    effPeriod = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef FROGGER_GAMESEQ_SPEEDUP_EN
      if (SC_GAMESEQ_lanePeriod_In[4*i +: 4] > {1'b0, SC_GAMESEQ_level_Out})
        effPeriod[i] = SC_GAMESEQ_lanePeriod_In[4*i +: 4] - {1'b0, SC_GAMESEQ_level_Out};
      else
        effPeriod[i] = 4'd0;
`else
      effPeriod[i] = SC_GAMESEQ_lanePeriod_In[4*i +: 4];
`endif
    end
  end

  // State register.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Next-state and Moore strobes; a move always wins over a pending tick so the
  // frog and the lanes never update on the same cycle.
  always_comb begin
    nextState                     = state;
    SC_GAMESEQ_laneShift_OutLow   = '1;
    SC_GAMESEQ_lanesClear_OutLow  = 1'b1;
    SC_GAMESEQ_playerClear_OutLow = 1'b1;
    SC_GAMESEQ_moveGrant_OutLow   = 1'b1;
    SC_GAMESEQ_gameOver_OutHigh   = 1'b0;
    case (state)
      IDLE: begin
        if (!SC_GAMESEQ_start_InLow)
          nextState = INIT;
      end
      INIT: begin
        SC_GAMESEQ_lanesClear_OutLow  = 1'b0;
        SC_GAMESEQ_playerClear_OutLow = 1'b0;
        nextState                     = TICK_WAIT;
      end
      TICK_WAIT: begin
        if (!SC_GAMESEQ_moveReq_InLow || pendMove)
          nextState = GRANT;
        else if (tick || pendTick)
          nextState = SHIFT;
      end
      GRANT: begin
        SC_GAMESEQ_moveGrant_OutLow = 1'b0;
        nextState                   = CHECK;
      end
      SHIFT: begin
        for (int i = 0; i < LANES; i++) begin
          if (shiftIdx == IDX_W'(i))
            SC_GAMESEQ_laneShift_OutLow[i] = ~dueMask[i];
        end
        if (shiftIdx == IDX_LAST)
          nextState = CHECK;
      end
      CHECK: begin
        if (SC_GAMESEQ_collision_InHigh)
          nextState = HIT;
        else if (SC_GAMESEQ_goal_InHigh)
          nextState = WIN;
        else
          nextState = TICK_WAIT;
      end
      HIT: begin
        SC_GAMESEQ_playerClear_OutLow = 1'b0;
        if (SC_GAMESEQ_lives_Out <= 3'd1)
          nextState = GAMEOVER;
        else
          nextState = TICK_WAIT;
      end
      WIN: begin
        SC_GAMESEQ_playerClear_OutLow = 1'b0;
        nextState                     = TICK_WAIT;
      end
      GAMEOVER: begin
        SC_GAMESEQ_gameOver_OutHigh = 1'b1;
        if (!SC_GAMESEQ_start_InLow)
          nextState = INIT;
      end
      default: nextState = IDLE;
    endcase
  end

  // Tick prescaler: cleared at game start, frozen outside active play.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh)
      prescaleCount <= '0;
    else if (state == INIT)
      prescaleCount <= '0;
    else if (running) begin
      if (prescaleCount == PRE_LAST)
        prescaleCount <= '0;
      else
        prescaleCount <= prescaleCount + PRE_W'(1);
    end
  end

  // Walks the lane index once per shift burst, one lane per cycle.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh)
      shiftIdx <= '0;
    else if (state == SHIFT && shiftIdx != IDX_LAST)
      shiftIdx <= shiftIdx + IDX_W'(1);
    else
      shiftIdx <= '0;
  end

  // Per-lane tick counters; the due mask is latched when a tick is serviced.
  // Using >= lets a lane catch up at once if its period shrank below its count.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      laneCount <= '0;
      dueMask   <= '0;
    end else if (state == INIT) begin
      laneCount <= '0;
      dueMask   <= '0;
    end else if (startShift) begin
      for (int i = 0; i < LANES; i++) begin
        if (laneCount[i] >= effPeriod[i]) begin
          dueMask[i]   <= 1'b1;
          laneCount[i] <= 4'd0;
        end else begin
          dueMask[i]   <= 1'b0;
          laneCount[i] <= laneCount[i] + 4'd1;
        end
      end
    end
  end

  // One-deep memory for a tick or move that arrives while the FSM is busy.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      pendTick <= 1'b0;
      pendMove <= 1'b0;
    end else if (state == INIT) begin
      pendTick <= 1'b0;
      pendMove <= 1'b0;
    end else begin
      if (startShift)
        pendTick <= 1'b0;
      else if (tick)
        pendTick <= 1'b1;
      if (state == GRANT)
        pendMove <= 1'b0;
      else if (moveCapture && !SC_GAMESEQ_moveReq_InLow)
        pendMove <= 1'b1;
    end
  end

  // Lives and level bookkeeping driven by the CHECK outcome states.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      SC_GAMESEQ_lives_Out <= LIVES_INIT;
      SC_GAMESEQ_level_Out <= 3'd0;
    end else if (state == INIT) begin
      SC_GAMESEQ_lives_Out <= LIVES_INIT;
      SC_GAMESEQ_level_Out <= 3'd0;
    end else if (state == HIT) begin
      if (SC_GAMESEQ_lives_Out != 3'd0)
        SC_GAMESEQ_lives_Out <= SC_GAMESEQ_lives_Out - 3'd1;
    end else if (state == WIN) begin
      if (SC_GAMESEQ_level_Out != LEVEL_MAX)
        SC_GAMESEQ_level_Out <= SC_GAMESEQ_level_Out + 3'd1;
    end
  end

endmodule

// File: tb/tb_sc_game_sequencer.sv
// tb_sc_game_sequencer: randomized bench for sc_game_sequencer.
// The reference model plans future cycles as a queue of activities (grant,
// lane strobes, check, hit/win) and decides lane due-ness from the number of
// ticks serviced since each lane last moved.
module tb_sc_game_sequencer;

  localparam int LANES    = 4;
  localparam int TICK_DIV = 4;
  localparam int LIVES    = 3;

  localparam int K_WAIT  = 0;
  localparam int K_INIT  = 1;
  localparam int K_GRANT = 2;
  localparam int K_SHIFT = 3;
  localparam int K_CHECK = 4;
  localparam int K_HIT   = 5;
  localparam int K_WIN   = 6;

  logic               clock;
  logic               reset;
  logic               startN;
  logic               moveReqN;
  logic [4*LANES-1:0] lanePeriod;
  logic [4*LANES-1:0] periodsReq;
  logic               collision;
  logic               goal;
  logic [LANES-1:0]   laneShift;
  logic               lanesClear;
  logic               playerClear;
  logic               moveGrant;
  logic [2:0]         lives;
  logic [2:0]         level;
  logic               gameOver;

  typedef struct {
    int               kind;
    logic [LANES-1:0] shiftVec;
  } stepT;

  stepT plan[$];
  bit   mRunning;
  bit   mOver;
  bit   mPendTick;
  bit   mPendMove;
  int   mLives;
  int   mLevel;
  int   mRunCycles;
  int   mServices;
  int   mLastDue[LANES];
  int   total;
  int   bad;

  sc_game_sequencer #(
    .LANES(LANES),
    .TICK_DIV(TICK_DIV),
    .LIVES(LIVES)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50(clock),
    .SC_STATEMACHINEPOINT_RESET_InHigh(reset),
    .SC_GAMESEQ_start_InLow(startN),
    .SC_GAMESEQ_moveReq_InLow(moveReqN),
    .SC_GAMESEQ_lanePeriod_In(lanePeriod),
    .SC_GAMESEQ_collision_InHigh(collision),
    .SC_GAMESEQ_goal_InHigh(goal),
    .SC_GAMESEQ_laneShift_OutLow(laneShift),
    .SC_GAMESEQ_lanesClear_OutLow(lanesClear),
    .SC_GAMESEQ_playerClear_OutLow(playerClear),
    .SC_GAMESEQ_moveGrant_OutLow(moveGrant),
    .SC_GAMESEQ_lives_Out(lives),
    .SC_GAMESEQ_level_Out(level),
    .SC_GAMESEQ_gameOver_OutHigh(gameOver)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic stepT mk(input int kind, input logic [LANES-1:0] vec);
    stepT s;
    s.kind     = kind;
    s.shiftVec = vec;
    return s;
  endfunction

  task automatic modelReset();
    plan.delete();
    mRunning   = 0;
    mOver      = 0;
    mPendTick  = 0;
    mPendMove  = 0;
    mLives     = LIVES;
    mLevel     = 0;
    mRunCycles = 0;
    mServices  = 0;
    foreach (mLastDue[i]) mLastDue[i] = 0;
  endtask

  // A serviced tick plans one strobe cycle per lane followed by a check.
  task automatic serviceTick();
    logic [LANES-1:0] dueVec;
    logic [LANES-1:0] vec;
    int p;
    int eff;
    mServices++;
    dueVec = '0;
    for (int i = 0; i < LANES; i++) begin
      p = int'(lanePeriod[4*i +: 4]);
`ifdef FROGGER_GAMESEQ_SPEEDUP_EN
      eff = (p > mLevel) ? p - mLevel : 0;
`else
      eff = p;
`endif
      if (mServices - mLastDue[i] >= eff + 1) begin
        dueVec[i]   = 1'b1;
        mLastDue[i] = mServices;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      vec = '1;
      if (dueVec[i]) vec[i] = 1'b0;
      plan.push_back(mk(K_SHIFT, vec));
    end
    plan.push_back(mk(K_CHECK, '1));
  endtask

  task automatic modelStep(input bit s, input bit m, input bit c, input bit g);
    stepT cur;
    bit   tickNow;
    if (!mRunning) begin
      if (!s) begin
        plan.push_back(mk(K_INIT, '1));
        mRunning = 1;
        mOver    = 0;
      end
      return;
    end
    if (plan.size() > 0) cur = plan.pop_front();
    else cur = mk(K_WAIT, '1);
    if (cur.kind == K_INIT) begin
      mLives     = LIVES;
      mLevel     = 0;
      mRunCycles = 0;
      mServices  = 0;
      mPendTick  = 0;
      mPendMove  = 0;
      foreach (mLastDue[i]) mLastDue[i] = 0;
      return;
    end
    tickNow = (mRunCycles % TICK_DIV) == TICK_DIV - 1;
    mRunCycles++;
    if (cur.kind == K_WAIT) begin
      if (!m || mPendMove) begin
        plan.push_back(mk(K_GRANT, '1));
        plan.push_back(mk(K_CHECK, '1));
        if (tickNow) mPendTick = 1;
      end else if (tickNow || mPendTick) begin
        serviceTick();
        mPendTick = 0;
      end
      return;
    end
    if (tickNow) mPendTick = 1;
    if (!m && cur.kind != K_GRANT) mPendMove = 1;
    case (cur.kind)
      K_GRANT: mPendMove = 0;
      K_CHECK: begin
        if (c) plan.push_back(mk(K_HIT, '1));
        else if (g) plan.push_back(mk(K_WIN, '1));
      end
      K_HIT: begin
        if (mLives == 1) begin
          mLives   = 0;
          mRunning = 0;
          mOver    = 1;
        end else begin
          mLives--;
        end
      end
      K_WIN: if (mLevel < 7) mLevel++;
      default: ;
    endcase
  endtask

  task automatic compareAll();
    int kind;
    logic [LANES-1:0] expShift;
    logic [LANES-1:0] lowBits;
    kind     = K_WAIT;
    expShift = '1;
    if (plan.size() > 0) begin
      kind = plan[0].kind;
      if (kind == K_SHIFT) expShift = plan[0].shiftVec;
    end
    lowBits = ~laneShift;
    checkOutput("laneShift", int'(laneShift), int'(expShift));
    checkOutput("strobeOverlap", int'($countones(lowBits) <= 1), 1);
    checkOutput("lanesClear", int'(lanesClear), (kind == K_INIT) ? 0 : 1);
    checkOutput("playerClear", int'(playerClear),
                (kind == K_INIT || kind == K_HIT || kind == K_WIN) ? 0 : 1);
    checkOutput("moveGrant", int'(moveGrant), (kind == K_GRANT) ? 0 : 1);
    checkOutput("lives", int'(lives), mLives);
    checkOutput("level", int'(level), mLevel);
    checkOutput("gameOver", int'(gameOver), int'(mOver));
  endtask

  // Periods are only changed while no game is running.
  task automatic applyStimulus(input bit s, input bit m, input bit c, input bit g);
    @(negedge clock);
    if (!mRunning) lanePeriod = periodsReq;
    startN    = s;
    moveReqN  = m;
    collision = c;
    goal      = g;
    #1;
    compareAll();
    modelStep(s, m, c, g);
  endtask

  task automatic runPhase(input int cycles, input int pStart, input int pMove,
                          input int pColl, input int pGoal);
    for (int n = 0; n < cycles; n++) begin
      applyStimulus(!(int'($urandom_range(99)) < pStart), !(int'($urandom_range(99)) < pMove),
                    int'($urandom_range(99)) < pColl, int'($urandom_range(99)) < pGoal);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_laneShift"}, int'(laneShift), (1 << LANES) - 1);
    checkOutput({tag, "_lanesClear"}, int'(lanesClear), 1);
    checkOutput({tag, "_playerClear"}, int'(playerClear), 1);
    checkOutput({tag, "_moveGrant"}, int'(moveGrant), 1);
    checkOutput({tag, "_lives"}, int'(lives), LIVES);
    checkOutput({tag, "_level"}, int'(level), 0);
    checkOutput({tag, "_gameOver"}, int'(gameOver), 0);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset      = 1'b1;
    startN     = 1'b1;
    moveReqN   = 1'b1;
    collision  = 1'b0;
    goal       = 1'b0;
    lanePeriod = periodsReq;
    modelReset();
    #1;
    checkResetValues("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Stops a burst mid-way with reset; strobes must release without a clock edge.
  task automatic midShiftReset();
    bit found;
    found = 0;
    periodsReq = '0;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 200 && !found; n++) begin
      if (plan.size() > 0 && plan[0].kind == K_SHIFT && plan[0].shiftVec == 4'b1101)
        found = 1;
      else
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("shiftReached", int'(found), 1);
    if (found) begin
      @(negedge clock);
      #1;
      compareAll();
      reset = 1'b1;
      #1;
      checkResetValues("midShift");
      modelReset();
      @(negedge clock);
      reset = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    startN     = 1'b1;
    moveReqN   = 1'b1;
    collision  = 1'b0;
    goal       = 1'b0;
    periodsReq = '0;
    lanePeriod = '0;
    modelReset();

    // All lanes due every tick: round-robin burst after each tick.
    doReset();
    runPhase(1, 100, 0, 0, 0);
    runPhase(40, 0, 0, 0, 0);

    // Mixed periods, then move requests racing the lane bursts.
    periodsReq = {4'd3, 4'd2, 4'd1, 4'd0};
    doReset();
    runPhase(1, 100, 0, 0, 0);
    runPhase(100, 0, 0, 0, 0);
    runPhase(200, 0, 15, 0, 0);

    // Goals only: level climbs and saturates.
    runPhase(150, 0, 0, 0, 100);
    checkOutput("levelSaturate", int'(level), 7);

    // Collision and goal together: hits win, level holds, game ends.
    runPhase(60, 0, 0, 100, 100);
    checkOutput("hitLevelHold", int'(level), 7);
    checkOutput("overLives", int'(lives), 0);
    checkOutput("overFlag", int'(gameOver), 1);
    runPhase(20, 0, 0, 0, 0);
    runPhase(1, 100, 0, 0, 0);
    runPhase(2, 0, 0, 0, 0);
    checkOutput("restartLives", int'(lives), LIVES);
    checkOutput("restartOver", int'(gameOver), 0);
    checkOutput("restartLevel", int'(level), 0);

    // Fully random games with random periods.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LANES; i++) periodsReq[4*i +: 4] = 4'($urandom_range(5));
      doReset();
      runPhase(400, 20, 10, 8, 12);
    end

    midShiftReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
